// File: rtl/main.sv
// Serial-loaded linear regressor trained by stochastic gradient descent.
// Records arrive bit-serially (LSB first, highest word index first) straight
// after reset release; training then runs PRED/UPDATE per record for the
// requested number of epochs. All arithmetic is signed Q8.8.
//
// The control inputs use a level protocol rather than a valid/ready handshake:
// feat, data_points, epoch and learn_rate are held stable from reset release
// until SGD_DONE rises, S is sampled on every rising edge while in LOAD, and
// SGD_DONE is a sticky level that only reset clears.
module main #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int LENGTH       = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  S,
  input  logic [3:0]            feat,
  input  logic [ADDR_WIDTH-1:0] data_points,
  input  logic [7:0]            epoch,
  input  logic [3:0]            learn_rate,
  input  logic [3:0]            w_addr,
  output logic [LENGTH-1:0]     w_data,
  output logic                  SGD_DONE,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_PRED   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int PW = 2 * LENGTH;
  localparam logic signed [PW:0] SAT_HI = (2 ** (LENGTH - 1)) - 1;
  localparam logic signed [PW:0] SAT_LO = -(2 ** (LENGTH - 1));

  state_t r_state;
  state_t w_state_next;

  // The first 15 bits of a word; the 16th is taken straight from S.
  logic [LENGTH-2:0]            r_shift;
  logic [3:0]                   r_bit;
  logic [3:0]                   r_word;
  logic [ADDR_WIDTH-1:0]        r_rec;
  logic [7:0]                   r_epoch;
  logic [3:0]                   r_term;
  logic signed [PW-1:0]         r_acc;
  logic signed [LENGTH-1:0]     r_w [0:15];
  logic [LENGTH-1:0]            r_mem [0:(2**ADDR_WIDTH)-1][0:MAX_FEATURES];

  logic                         w_last_bit;
  logic                         w_last_word;
  logic                         w_last_rec;
  logic                         w_last_term;
  logic                         w_last_epoch;
  logic                         w_mem_we;
  logic [3:0]                   w_widx;
  logic [LENGTH-1:0]            w_word;
  logic signed [LENGTH-1:0]     w_x;
  logic signed [LENGTH-1:0]     w_y;
  logic signed [LENGTH-1:0]     w_wt;
  logic signed [PW-1:0]         w_prod;
  logic signed [PW:0]           w_diff;
  logic signed [LENGTH-1:0]     w_err;
  logic signed [PW-1:0]         w_err_x;
  logic signed [PW-1:0]         w_upd;
  logic signed [PW:0]           w_new_wide;
  logic signed [LENGTH-1:0]     w_new;

  function automatic logic signed [LENGTH-1:0] sat(input logic signed [PW:0] v);
    if (v > SAT_HI)      sat = SAT_HI[LENGTH-1:0];
    else if (v < SAT_LO) sat = SAT_LO[LENGTH-1:0];
    else                 sat = v[LENGTH-1:0];
  endfunction

  assign w_last_bit   = (r_bit == 4'd15);
  assign w_last_word  = (r_word == feat);
  assign w_last_rec   = (r_rec == data_points);
  assign w_last_term  = (r_term == feat);
  assign w_last_epoch = ((r_epoch + 8'd1) == epoch);

  // Load path: word counter counts up, storage index runs F down to 0.
  assign w_widx   = feat - r_word;
  assign w_word   = {S, r_shift};
  assign w_mem_we = (r_state == ST_LOAD) && w_last_bit;

  // Training datapath: one term (PRED) or one weight (UPDATE) per cycle.
  assign w_x        = $signed(r_mem[r_rec][r_term]);
  assign w_y        = $signed(r_mem[r_rec][0]);
  assign w_wt       = r_w[r_term];
  assign w_prod     = w_wt * w_x;
  assign w_diff     = $signed({r_acc[PW-1], r_acc}) - $signed({{(LENGTH+1){w_y[LENGTH-1]}}, w_y});
  assign w_err      = sat(w_diff);
  assign w_err_x    = w_err * w_x;
  assign w_upd      = (r_term == 4'd0)
                    ? ($signed({{LENGTH{w_err[LENGTH-1]}}, w_err}) >>> learn_rate)
                    : ((w_err_x >>> 8) >>> learn_rate);
  assign w_new_wide = $signed({{(LENGTH+1){w_wt[LENGTH-1]}}, w_wt}) - $signed({w_upd[PW-1], w_upd});
  assign w_new      = sat(w_new_wide);

  assign w_data   = (w_addr > feat) ? '0 : r_w[w_addr];
  assign SGD_DONE = (r_state == ST_DONE);
  assign o_state  = r_state;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_LOAD;
    else      r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_last_bit && w_last_word && w_last_rec)
          w_state_next = (epoch == 8'd0) ? ST_DONE : ST_PRED;
      end
      ST_PRED: begin
        if (w_last_term) w_state_next = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (w_last_term)
          w_state_next = (w_last_rec && w_last_epoch) ? ST_DONE : ST_PRED;
      end
      default: w_state_next = ST_DONE;
    endcase
  end

  // Record storage write; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (w_mem_we) r_mem[r_rec][w_widx] <= w_word;
  end

  // Counters, accumulator and weights.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift <= '0;
      r_bit   <= '0;
      r_word  <= '0;
      r_rec   <= '0;
      r_epoch <= '0;
      r_term  <= '0;
      r_acc   <= '0;
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_shift <= w_word[LENGTH-1:1];
          r_bit   <= r_bit + 4'd1;
          if (w_last_bit) begin
            if (w_last_word) begin
              r_word <= '0;
              r_rec  <= w_last_rec ? '0 : r_rec + 1'b1;
            end else begin
              r_word <= r_word + 4'd1;
            end
          end
        end
        ST_PRED: begin
          if (r_term == 4'd0) r_acc <= $signed({{LENGTH{w_wt[LENGTH-1]}}, w_wt});
          else                r_acc <= r_acc + (w_prod >>> 8);
          r_term <= w_last_term ? 4'd0 : r_term + 4'd1;
        end
        ST_UPDATE: begin
          r_w[r_term] <= w_new;
          r_term      <= w_last_term ? 4'd0 : r_term + 4'd1;
          if (w_last_term) begin
            if (w_last_rec) begin
              r_rec   <= '0;
              r_epoch <= r_epoch + 8'd1;
            end else begin
              r_rec <= r_rec + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_main.sv
// Directed bench for the serial-load SGD regressor.
module tb_main;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_PRED = 2'd1;

  logic        CLK;
  logic        RST;
  logic        S;
  logic [3:0]  feat;
  logic [11:0] data_points;
  logic [7:0]  epoch;
  logic [3:0]  learn_rate;
  logic [3:0]  w_addr;
  logic [15:0] w_data;
  logic        SGD_DONE;
  logic [1:0]  o_state;

  int n_checks;
  int n_errors;

  logic [15:0] rec_y [0:1];
  logic [15:0] rec_x [0:1][0:15];

  main dut (
    .CLK         (CLK),
    .RST         (RST),
    .S           (S),
    .feat        (feat),
    .data_points (data_points),
    .epoch       (epoch),
    .learn_rate  (learn_rate),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .SGD_DONE    (SGD_DONE),
    .o_state     (o_state)
  );

  // Clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hold reset with the given configuration, then release and stream the records.
  task automatic start_run(input logic [3:0] f, input logic [11:0] n,
                           input logic [7:0] e, input logic [3:0] l);
    logic [15:0] word;
    RST = 1'b0;
    S = 1'b0;
    feat = f;
    data_points = n;
    epoch = e;
    learn_rate = l;
    w_addr = 4'd0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int r = 0; r <= int'(n); r++) begin
      for (int idx = int'(f); idx >= 0; idx--) begin
        word = (idx == 0) ? rec_y[r] : rec_x[r][idx];
        for (int b = 0; b < 16; b++) begin
          S = word[b];
          @(negedge CLK);
        end
      end
    end
    S = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 2000 && !SGD_DONE; i++) @(negedge CLK);
    check(tag, {15'd0, SGD_DONE}, 16'd1);
  endtask

  task automatic read_w(input string tag, input logic [3:0] a, input logic [15:0] exp);
    w_addr = a;
    #1;
    check(tag, w_data, exp);
  endtask

  task automatic set_rec(input int r, input logic [15:0] y, input logic [15:0] x1);
    rec_y[r] = y;
    rec_x[r][1] = x1;
  endtask

  initial begin
    int entries;
    logic [1:0] prev;
    n_checks = 0;
    n_errors = 0;
    RST = 1'b0;
    S = 1'b0;
    feat = 4'd15;
    data_points = '0;
    epoch = 8'd1;
    learn_rate = 4'd0;
    w_addr = 4'd0;
    for (int r = 0; r < 2; r++) begin
      rec_y[r] = '0;
      for (int i = 0; i < 16; i++) rec_x[r][i] = '0;
    end

    // Reset state: everything cleared, every weight address reads zero.
    repeat (3) @(negedge CLK);
    check("rst_done", {15'd0, SGD_DONE}, 16'd0);
    check("rst_state", {14'd0, o_state}, {14'd0, ST_LOAD});
    for (int a = 0; a < 16; a++) read_w($sformatf("rst_w%0d", a), 4'(a), 16'h0000);

    // Single step, L=0: err = -1.0, both weights step to +1.0.
    set_rec(0, 16'h0100, 16'h0100);
    start_run(4'd1, 12'd0, 8'd1, 4'd0);
    check("l0_busy", {15'd0, SGD_DONE}, 16'd0);
    wait_done("l0_done");
    read_w("l0_w0", 4'd0, 16'h0100);
    read_w("l0_w1", 4'd1, 16'h0100);
    read_w("l0_w2_above_f", 4'd2, 16'h0000);
    read_w("l0_w15_above_f", 4'd15, 16'h0000);
    repeat (5) @(negedge CLK);
    read_w("l0_frozen_w0", 4'd0, 16'h0100);
    check("l0_still_done", {15'd0, SGD_DONE}, 16'd1);

    // Single step, L=2: step scaled by 1/4.
    start_run(4'd1, 12'd0, 8'd1, 4'd2);
    wait_done("l2_done");
    read_w("l2_w0", 4'd0, 16'h0040);
    read_w("l2_w1", 4'd1, 16'h0040);

    // L=15: -256 >>> 15 = -1, so each weight moves by exactly one LSB.
    start_run(4'd1, 12'd0, 8'd1, 4'd15);
    wait_done("l15_done");
    read_w("l15_w0", 4'd0, 16'h0001);
    read_w("l15_w1", 4'd1, 16'h0001);

    // y = -128.0, x1 = 0x7FFF: acc - y = +32768 clamps err to 0x7FFF,
    // w0 = 0 - 32767 = 0x8001, w1 = 0 - (32767*32767 >>> 8) clamps to 0x8000.
    set_rec(0, 16'h8000, 16'h7FFF);
    start_run(4'd1, 12'd0, 8'd1, 4'd0);
    wait_done("satn_done");
    read_w("satn_w0", 4'd0, 16'h8001);
    read_w("satn_w1", 4'd1, 16'h8000);

    // Mirror case: err = -32767, w0 = +32767, w1 clamps to 0x7FFF.
    set_rec(0, 16'h7FFF, 16'h7FFF);
    start_run(4'd1, 12'd0, 8'd1, 4'd0);
    wait_done("satp_done");
    read_w("satp_w0", 4'd0, 16'h7FFF);
    read_w("satp_w1", 4'd1, 16'h7FFF);

    // E=0: done is visible right after the edge that takes the last bit.
    set_rec(0, 16'h0100, 16'h0100);
    start_run(4'd1, 12'd0, 8'd0, 4'd0);
    check("e0_done_now", {15'd0, SGD_DONE}, 16'd1);
    read_w("e0_w0", 4'd0, 16'h0000);
    read_w("e0_w1", 4'd1, 16'h0000);

    // Two records, two epochs, L=1. Hand trace (decimal Q8.8 raw):
    //   e1r0 err=-512 -> w=(256,256); e1r1 err=128 -> w=(192,224)
    //   e2r0 err=-96  -> w=(240,272); e2r1 err=120 -> w=(180,242)
    set_rec(0, 16'h0200, 16'h0100);
    set_rec(1, 16'h0100, 16'h0080);
    start_run(4'd1, 12'd1, 8'd2, 4'd1);
    wait_done("multi_done");
    read_w("multi_w0", 4'd0, 16'h00B4);
    read_w("multi_w1", 4'd1, 16'h00F2);

    // Same run, aborted by reset on entry to the first PRED of epoch 2.
    start_run(4'd1, 12'd1, 8'd2, 4'd1);
    entries = (o_state == ST_PRED) ? 1 : 0;
    prev = o_state;
    for (int i = 0; i < 200 && entries < 3; i++) begin
      @(negedge CLK);
      if (o_state == ST_PRED && prev != ST_PRED) entries++;
      prev = o_state;
    end
    check("abort_reached_e2_pred", 16'(entries), 16'd3);
    read_w("abort_pre_w0", 4'd0, 16'h00C0);
    RST = 1'b0;
    #1;
    check("abort_done", {15'd0, SGD_DONE}, 16'd0);
    check("abort_state", {14'd0, o_state}, {14'd0, ST_LOAD});
    read_w("abort_w0", 4'd0, 16'h0000);
    read_w("abort_w1", 4'd1, 16'h0000);
    start_run(4'd1, 12'd1, 8'd2, 4'd1);
    wait_done("rerun_done");
    read_w("rerun_w0", 4'd0, 16'h00B4);
    read_w("rerun_w1", 4'd1, 16'h00F2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
